term_ctrl: RTL and testbench
============================

# term_ctrl

Serial-terminal controller between a character source (UART receiver) and the shared text-mode VRAM port. It interprets each byte (printable, CR, LF, BS, FF) and keeps the cursor position. It writes glyph codes into VRAM and sequences the scroll engine when the cursor leaves the last row. It also owns the VRAM port mux, handing the port to the scroll engine only while a scroll is in progress.

## Interface
- COLS, 60, text columns (x = 0..COLS-1)
- ROWS, 17, text rows (y = 0..ROWS-1)
- i_clk  in  1  system clock (24 MHz)
- i_rst  in  1  reset; synchronous, active-high
- i_char_valid  in  1  source has a byte
- i_char  in  8  byte from source
- o_char_ready  out  1  controller accepts byte this cycle
- o_scroll_start  out  1  one-cycle start pulse to scroll engine
- i_scroll_running  in  1  scroll engine busy
- i_scr_addr / i_scr_din / i_scr_ce / i_scr_wre  in  11/8/1/1  scroll engine VRAM request
- o_vram_addr  out  11  VRAM address {y[4:0], x[5:0]}
- o_vram_din  out  8  VRAM write data
- o_vram_ce  out  1  VRAM clock enable
- o_vram_wre  out  1  VRAM write (1) / read (0)
- o_cursor_x  out  6  cursor column
- o_cursor_y  out  5  cursor row
- o_busy  out  1  equals ~o_char_ready

## Operation
- States: S_RSTWAIT, S_IDLE, S_WRITE, S_SCR_START, S_SCR_ARM, S_SCR_WAIT, S_CLEAR.
- Reset: state S_RSTWAIT; cursor (0,0); o_char_ready 0; o_scroll_start 0; own VRAM outputs ce=0, wre=0, addr=0, din=0.
- S_RSTWAIT: go to S_IDLE once i_scroll_running==0. This covers reset during a scroll.
- S_IDLE: o_char_ready=1. Byte accepted on i_char_valid & o_char_ready. Decode:
  - 0x20..0x7E: go to S_WRITE with addr={y,x}, din=byte.
  - 0x0D CR: x=0, stay in S_IDLE.
  - 0x0A LF: newline, defined below.
  - 0x08 BS: if x>0, x=x-1 and go to S_WRITE with din=0x20 at the new x; if x==0, no-op.
  - 0x0C FF: go to S_CLEAR.
  - Any other byte: dropped, no state change.
- S_WRITE: one cycle with ce=1, wre=1.
  - After a printable write: x=x+1.
  - If x was COLS-1: x=0, then newline.
  - After a BS write: cursor unchanged.
  - Return to S_IDLE unless the newline needs a scroll.
- Newline: if y<ROWS-1, y=y+1. If y==ROWS-1, y is unchanged and the FSM goes to S_SCR_START.
- S_SCR_START: o_scroll_start=1 for exactly one cycle; VRAM mux switches to the scroll engine.
- S_SCR_ARM: wait for i_scroll_running==1.
- S_SCR_WAIT: wait for i_scroll_running==0, then go to S_IDLE and return the mux to the controller.
- S_CLEAR: counter walks y 0..ROWS-1 and, within each row, x 0..COLS-1. One write of 0x20 per cycle (ROWS*COLS = 1020 cycles); addresses x=COLS..63 are skipped. Afterwards cursor=(0,0), go to S_IDLE.
- Mux: while state is S_SCR_START, S_SCR_ARM or S_SCR_WAIT, o_vram_* = i_scr_*. In all other states o_vram_* = controller registers. Select is decoded from the registered state only.
- Own ce/wre are 0 in every state except S_WRITE and S_CLEAR.

## Timing
- Printable byte accepted at cycle N:
  - VRAM write at N+1.
  - Cursor updated at N+2.
  - o_char_ready high again at N+2.
- CR and LF (no scroll), and BS at x=0: ready again at N+1 with the cursor already updated.
- Scroll after the write at N+1: o_scroll_start pulses at N+2; ready returns one cycle after i_scroll_running falls.
- The scroll engine raises running one cycle after sampling the start pulse. S_SCR_ARM tolerates any delay.
- FF accepted at N: writes at N+1..N+1020; ready at N+1021.
- Cursor arithmetic is unsigned with no wrap outside 0..COLS-1 / 0..ROWS-1.
- Address is a concatenation, never the product y*COLS+x.
- i_rst dominates every state, including mid-clear and mid-scroll.

## Structure
- Package term_pkg: COLS, ROWS, control codes (CHR_BS=0x08, CHR_LF=0x0A, CHR_FF=0x0C, CHR_CR=0x0D, CHR_SP=0x20), state enum, VRAM address width 11.
- Sub-module term_vram_mux: combinational 2:1 port mux with select input. All other logic stays in term_ctrl.

## Test plan
- Reset, then 'A' (0x41): one write addr=0x000 din=0x41; cursor (1,0); ready low for exactly 1 cycle.
- Cursor at (59,3), send 'Z': write addr={5'd3,6'd59} din=0x5A; cursor becomes (0,4); no scroll pulse.
- Cursor at (10,16), send LF: single o_scroll_start pulse; controller ce stays 0 while running; mux forwards i_scr_*; cursor (10,16); ready returns 1 cycle after running falls.
- Cursor at (5,2), send BS, BS, CR: writes 0x20 at x=4, then at x=3; cursor (3,2), then (0,2). Send BS at x=0: no write.
- Send FF: exactly 1020 writes of 0x20, no address with x≥60; cursor (0,0); ready at N+1021.
- Assert i_rst mid-clear while i_scroll_running=1: ready stays 0 until running drops; cursor (0,0); all own outputs at reset values.

Source files
------------

// File: rtl/term_pkg.sv
// term_pkg: shared geometry, control codes and types for the
// serial-terminal controller and its VRAM port mux.
package term_pkg;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int AW   = 11;
  localparam int XW   = 6;
  localparam int YW   = 5;

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_SP = 8'h20;
  localparam logic [7:0] CHR_HI = 8'h7E;

  typedef enum logic [2:0] {
    S_RSTWAIT,
    S_IDLE,
    S_WRITE,
    S_SCR_START,
    S_SCR_ARM,
    S_SCR_WAIT,
    S_CLEAR
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          ce;
    logic          wre;
  } vram_req_t;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= CHR_SP) && (c <= CHR_HI);
  endfunction

  function automatic logic [AW-1:0] cell_addr(
    input logic [YW-1:0] y,
    input logic [XW-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/term_vram_mux.sv
// term_vram_mux: 2:1 VRAM port select between the terminal
// controller and the scroll engine.
module term_vram_mux
  import term_pkg::*;
(
  input  logic      sel_scr_i,
  input  vram_req_t ctrl_i,
  input  vram_req_t scr_i,
  output vram_req_t vram_o
);

  assign vram_o = sel_scr_i ? scr_i : ctrl_i;

endmodule

// File: rtl/term_ctrl.sv
// term_ctrl: byte interpreter, cursor keeper, screen clear and
// scroll sequencing in front of the shared text VRAM port.
module term_ctrl
  import term_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_char_valid,
  input  logic [7:0]    i_char,
  output logic          o_char_ready,
  output logic          o_scroll_start,
  input  logic          i_scroll_running,
  input  logic [AW-1:0] i_scr_addr,
  input  logic [7:0]    i_scr_din,
  input  logic          i_scr_ce,
  input  logic          i_scr_wre,
  output logic [AW-1:0] o_vram_addr,
  output logic [7:0]    o_vram_din,
  output logic          o_vram_ce,
  output logic          o_vram_wre,
  output logic [XW-1:0] o_cursor_x,
  output logic [YW-1:0] o_cursor_y,
  output logic          o_busy
);

  state_e        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          ready_q;
  logic          start_q;
  logic          bs_q;
  vram_req_t     own_q;

  logic          accept;
  logic          scr_sel;
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [XW-1:0] clr_x_d;
  logic [YW-1:0] clr_y_d;
  logic          clr_last;
  vram_req_t     scr_req;
  vram_req_t     vram;

  assign accept = i_char_valid & ready_q;

  // The clear walk reuses the own address register as its counter.
  assign clr_x = own_q.addr[XW-1:0];
  assign clr_y = own_q.addr[AW-1:XW];
  assign clr_last = (clr_x == X_MAX) && (clr_y == Y_MAX);

  always_comb begin
    clr_x_d = clr_x + XW'(1);
    clr_y_d = clr_y;
    if (clr_x == X_MAX) begin
      clr_x_d = '0;
      clr_y_d = clr_y + YW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_RSTWAIT;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      bs_q    <= 1'b0;
      own_q   <= '0;
    end else begin
      own_q.ce  <= 1'b0;
      own_q.wre <= 1'b0;
      start_q   <= 1'b0;
      unique case (state_q)
        S_RSTWAIT: begin
          if (!i_scroll_running) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_print(i_char): begin
                state_q    <= S_WRITE;
                ready_q    <= 1'b0;
                bs_q       <= 1'b0;
                own_q.addr <= cell_addr(y_q, x_q);
                own_q.din  <= i_char;
                own_q.ce   <= 1'b1;
                own_q.wre  <= 1'b1;
              end
              (i_char == CHR_CR): begin
                x_q <= '0;
              end
              (i_char == CHR_LF): begin
                if (y_q == Y_MAX) begin
                  state_q <= S_SCR_START;
                  start_q <= 1'b1;
                  ready_q <= 1'b0;
                end else begin
                  y_q <= y_q + YW'(1);
                end
              end
              (i_char == CHR_BS): begin
                if (x_q != '0) begin
                  state_q    <= S_WRITE;
                  ready_q    <= 1'b0;
                  bs_q       <= 1'b1;
                  x_q        <= x_q - XW'(1);
                  own_q.addr <= cell_addr(y_q, x_q - XW'(1));
                  own_q.din  <= CHR_SP;
                  own_q.ce   <= 1'b1;
                  own_q.wre  <= 1'b1;
                end
              end
              (i_char == CHR_FF): begin
                state_q    <= S_CLEAR;
                ready_q    <= 1'b0;
                own_q.addr <= '0;
                own_q.din  <= CHR_SP;
                own_q.ce   <= 1'b1;
                own_q.wre  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          if (bs_q) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else if (x_q == X_MAX) begin
            x_q <= '0;
            if (y_q == Y_MAX) begin
              state_q <= S_SCR_START;
              start_q <= 1'b1;
            end else begin
              y_q     <= y_q + YW'(1);
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            x_q     <= x_q + XW'(1);
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_SCR_START: begin
          state_q <= S_SCR_ARM;
        end
        S_SCR_ARM: begin
          if (i_scroll_running) begin
            state_q <= S_SCR_WAIT;
          end
        end
        S_SCR_WAIT: begin
          if (!i_scroll_running) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_last) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end else begin
            own_q.addr <= cell_addr(clr_y_d, clr_x_d);
            own_q.ce   <= 1'b1;
            own_q.wre  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RSTWAIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign scr_sel = (state_q == S_SCR_START) ||
                   (state_q == S_SCR_ARM) ||
                   (state_q == S_SCR_WAIT);

  assign scr_req.addr = i_scr_addr;
  assign scr_req.din  = i_scr_din;
  assign scr_req.ce   = i_scr_ce;
  assign scr_req.wre  = i_scr_wre;

  term_vram_mux u_mux (
    .sel_scr_i (scr_sel),
    .ctrl_i    (own_q),
    .scr_i     (scr_req),
    .vram_o    (vram)
  );

  assign o_vram_addr    = vram.addr;
  assign o_vram_din     = vram.din;
  assign o_vram_ce      = vram.ce;
  assign o_vram_wre     = vram.wre;
  assign o_char_ready   = ready_q;
  assign o_busy         = ~ready_q;
  assign o_scroll_start = start_q;
  assign o_cursor_x     = x_q;
  assign o_cursor_y     = y_q;

endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: randomized and directed bench for term_ctrl with a
// cursor/VRAM reference model and a small scroll engine responder.
module tb_term_ctrl;
  import term_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_char_valid;
  logic [7:0]    i_char;
  logic          o_char_ready;
  logic          o_scroll_start;
  logic          i_scroll_running;
  logic [AW-1:0] i_scr_addr;
  logic [7:0]    i_scr_din;
  logic          i_scr_ce;
  logic          i_scr_wre;
  logic [AW-1:0] o_vram_addr;
  logic [7:0]    o_vram_din;
  logic          o_vram_ce;
  logic          o_vram_wre;
  logic [XW-1:0] o_cursor_x;
  logic [YW-1:0] o_cursor_y;
  logic          o_busy;

  term_ctrl dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_char_valid     (i_char_valid),
    .i_char           (i_char),
    .o_char_ready     (o_char_ready),
    .o_scroll_start   (o_scroll_start),
    .i_scroll_running (i_scroll_running),
    .i_scr_addr       (i_scr_addr),
    .i_scr_din        (i_scr_din),
    .i_scr_ce         (i_scr_ce),
    .i_scr_wre        (i_scr_wre),
    .o_vram_addr      (o_vram_addr),
    .o_vram_din       (o_vram_din),
    .o_vram_ce        (o_vram_ce),
    .o_vram_wre       (o_vram_wre),
    .o_cursor_x       (o_cursor_x),
    .o_cursor_y       (o_cursor_y),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // scroll engine responder
  logic eng_en = 1'b1;
  logic eng_run = 1'b0;
  logic man_run = 1'b0;
  int   fall_cyc = 0;
  assign i_scroll_running = eng_run | man_run;

  initial begin
    int d;
    int n;
    i_scr_addr = '0;
    i_scr_din  = '0;
    i_scr_ce   = 1'b0;
    i_scr_wre  = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (eng_en && o_scroll_start === 1'b1) begin
        d = $urandom_range(1, 3);
        repeat (d) begin @(posedge i_clk); #1; end
        eng_run = 1'b1;
        n = $urandom_range(3, 8);
        repeat (n) begin
          i_scr_addr = 11'($urandom);
          i_scr_din  = 8'($urandom);
          i_scr_ce   = 1'b1;
          i_scr_wre  = 1'($urandom);
          @(posedge i_clk); #1;
        end
        eng_run   = 1'b0;
        i_scr_ce  = 1'b0;
        i_scr_wre = 1'b0;
        fall_cyc  = cyc;
      end
    end
  end

  // observed traffic
  int         wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  int         pulses = 0;
  int         pulse_cyc = 0;
  int         fwd_bad = 0;
  int         busy_bad = 0;

  always @(negedge i_clk) begin
    if (o_vram_ce === 1'b1 && o_vram_wre === 1'b1 &&
        !(eng_en && i_scroll_running)) begin
      wa.push_back(int'(o_vram_addr));
      wd.push_back(o_vram_din);
      wc.push_back(cyc);
    end
    if (o_scroll_start === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
    end
    if (eng_en && i_scroll_running &&
        ({o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre} !==
         {i_scr_addr, i_scr_din, i_scr_ce, i_scr_wre}))
      fwd_bad++;
    if (o_busy !== ~o_char_ready) busy_bad++;
  end

  // reference model
  int         mx = 0;
  int         my = 0;
  int         ea[$];
  logic [7:0] ed[$];
  int         exp_scr;
  int         exp_lat;

  task automatic model_newline();
    if (my < ROWS - 1) my++;
    else exp_scr = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ea.delete();
    ed.delete();
    exp_scr = 0;
    exp_lat = 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      ea.push_back(my * 64 + mx);
      ed.push_back(b);
      exp_lat = 2;
      mx++;
      if (mx == COLS) begin
        mx = 0;
        model_newline();
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        ea.push_back(my * 64 + mx);
        ed.push_back(8'h20);
        exp_lat = 2;
      end
    end else if (b == 8'h0C) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) begin
          ea.push_back(y * 64 + x);
          ed.push_back(8'h20);
        end
      mx = 0;
      my = 0;
      exp_lat = ROWS * COLS + 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int t;
    t = 0;
    @(negedge i_clk);
    while (o_char_ready !== 1'b1 && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    if (o_char_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: ready=%b required 1", o_char_ready);
    end
    i_char_valid = 1'b1;
    i_char = b;
    acc = cyc;
    @(negedge i_clk);
    i_char_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int t;
    t = 0;
    while (o_char_ready !== 1'b1 && t < 3000) begin
      @(negedge i_clk);
      t++;
    end
    if (o_char_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ready=%b required 1", o_char_ready);
    end
    rc = cyc;
  endtask

  task automatic apply(input logic [7:0] b);
    int acc;
    int rc;
    int bad;
    model_byte(b);
    wa.delete();
    wd.delete();
    wc.delete();
    pulses = 0;
    fwd_bad = 0;
    send_byte(b, acc);
    wait_ready(rc);
    n_cmp++;
    if (wa.size() != ea.size()) begin
      n_err++;
      $display("FAIL wr_count byte=%02h: got %0d required %0d",
               b, wa.size(), ea.size());
    end
    bad = 0;
    foreach (ea[i])
      if (i < wa.size())
        if (wa[i] != ea[i] || wd[i] !== ed[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wr_data byte=%02h: %0d bad writes, required 0",
               b, bad);
    end
    if (wa.size() > 0 && ea.size() > 0) begin
      n_cmp++;
      if (wc[wc.size()-1] != acc + ea.size()) begin
        n_err++;
        $display("FAIL wr_cycle byte=%02h: got %0d required %0d",
                 b, wc[wc.size()-1] - acc, ea.size());
      end
    end
    n_cmp++;
    if (pulses != exp_scr) begin
      n_err++;
      $display("FAIL scroll_pulses byte=%02h: got %0d required %0d",
               b, pulses, exp_scr);
    end
    n_cmp++;
    if (o_cursor_x !== 6'(mx) || o_cursor_y !== 5'(my)) begin
      n_err++;
      $display("FAIL cursor byte=%02h: got (%0d,%0d) required (%0d,%0d)",
               b, o_cursor_x, o_cursor_y, mx, my);
    end
    if (exp_scr != 0) begin
      n_cmp++;
      if (rc != fall_cyc + 1) begin
        n_err++;
        $display("FAIL scroll_ready byte=%02h: got %0d required %0d",
                 b, rc - fall_cyc, 1);
      end
      n_cmp++;
      if (pulse_cyc != acc + exp_lat) begin
        n_err++;
        $display("FAIL pulse_cycle byte=%02h: got N+%0d required N+%0d",
                 b, pulse_cyc - acc, exp_lat);
      end
      n_cmp++;
      if (fwd_bad != 0) begin
        n_err++;
        $display("FAIL mux_forward: got %0d bad cycles required 0",
                 fwd_bad);
      end
    end else begin
      n_cmp++;
      if (rc - acc != exp_lat) begin
        n_err++;
        $display("FAIL ready_latency byte=%02h: got %0d required %0d",
                 b, rc - acc, exp_lat);
      end
    end
  endtask

  task automatic apply_prints(input int n);
    for (int i = 0; i < n; i++) apply(8'($urandom_range(32, 126)));
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (o_char_ready !== 1'b0 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b/%b required 0/1",
               o_char_ready, o_busy);
    end
    n_cmp++;
    if (o_scroll_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_start: got %b required 0", o_scroll_start);
    end
    n_cmp++;
    if ({o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_vram: got %h required 0",
               {o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre});
    end
    n_cmp++;
    if (o_cursor_x !== 6'd0 || o_cursor_y !== 5'd0) begin
      n_err++;
      $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)",
               o_cursor_x, o_cursor_y);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_char_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_exit_ready: got %b required 1", o_char_ready);
    end
    mx = 0;
    my = 0;
  endtask

  task automatic test_print_a();
    apply(8'h41);
    n_cmp++;
    if (wa.size() != 1 || wa[0] != 0 || wd[0] !== 8'h41) begin
      n_err++;
      $display("FAIL print_a: got %0d writes required 1 at 0 of 41",
               wa.size());
    end
  endtask

  task automatic test_wrap();
    apply(CHR_FF);
    repeat (3) apply(CHR_LF);
    apply_prints(59);
    apply(8'h5A);
    n_cmp++;
    if (wa.size() != 1 || wa[0] != 251 || wd[0] !== 8'h5A) begin
      n_err++;
      $display("FAIL wrap_write: got %0d writes required 1 at 0fb of 5a",
               wa.size());
    end
    n_cmp++;
    if (o_cursor_x !== 6'd0 || o_cursor_y !== 5'd4 || pulses != 0) begin
      n_err++;
      $display("FAIL wrap_cursor: got (%0d,%0d) p=%0d required (0,4) p=0",
               o_cursor_x, o_cursor_y, pulses);
    end
  endtask

  task automatic test_scroll();
    apply(CHR_FF);
    repeat (16) apply(CHR_LF);
    apply_prints(10);
    apply(CHR_LF);
    n_cmp++;
    if (o_cursor_x !== 6'd10 || o_cursor_y !== 5'd16 || pulses != 1) begin
      n_err++;
      $display("FAIL lf_scroll: got (%0d,%0d) p=%0d required (10,16) p=1",
               o_cursor_x, o_cursor_y, pulses);
    end
  endtask

  task automatic test_wrap_scroll();
    apply_prints(49);
    apply(8'h57);
    n_cmp++;
    if (o_cursor_x !== 6'd0 || o_cursor_y !== 5'd16 || pulses != 1) begin
      n_err++;
      $display("FAIL wrap_scroll: got (%0d,%0d) p=%0d required (0,16) p=1",
               o_cursor_x, o_cursor_y, pulses);
    end
  endtask

  task automatic test_bs();
    apply(CHR_FF);
    repeat (2) apply(CHR_LF);
    apply_prints(5);
    apply(CHR_BS);
    apply(CHR_BS);
    n_cmp++;
    if (wa.size() != 1 || wa[0] != 131 || wd[0] !== 8'h20) begin
      n_err++;
      $display("FAIL bs_write: got %0d writes required 1 at 083 of 20",
               wa.size());
    end
    apply(CHR_CR);
    apply(CHR_BS);
    n_cmp++;
    if (wa.size() != 0 || o_cursor_x !== 6'd0 || o_cursor_y !== 5'd2) begin
      n_err++;
      $display("FAIL bs_at_0: got %0d writes (%0d,%0d) required 0 (0,2)",
               wa.size(), o_cursor_x, o_cursor_y);
    end
  endtask

  task automatic test_clear();
    int bad;
    apply_prints(7);
    apply(CHR_FF);
    bad = 0;
    foreach (wa[i]) if ((wa[i] % 64) >= COLS) bad++;
    n_cmp++;
    if (bad != 0 || wa.size() != 1020) begin
      n_err++;
      $display("FAIL clear_walk: got %0d writes %0d off-screen required 1020 0",
               wa.size(), bad);
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] b;
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      if (r < 65) b = 8'($urandom_range(32, 126));
      else if (r < 78) b = CHR_LF;
      else if (r < 84) b = CHR_CR;
      else if (r < 95) b = CHR_BS;
      else if (r < 99) begin
        case ($urandom_range(0, 2))
          0: b = 8'($urandom_range(0, 7));
          1: b = 8'h7F;
          default: b = 8'($urandom_range(128, 255));
        endcase
      end else b = CHR_FF;
      apply(b);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int bad;
    apply(8'h51);
    eng_en = 1'b0;
    send_byte(CHR_FF, acc);
    repeat (100) @(negedge i_clk);
    man_run = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    wa.delete();
    bad = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_char_ready !== 1'b0 || o_scroll_start !== 1'b0 ||
          {o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre} !== 21'd0 ||
          o_cursor_x !== 6'd0 || o_cursor_y !== 5'd0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rst_mid_hold: got %0d bad cycles required 0", bad);
    end
    n_cmp++;
    if (wa.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_writes: got %0d required 0", wa.size());
    end
    man_run = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_char_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_release: got %b required 1", o_char_ready);
    end
    eng_en = 1'b1;
    mx = 0;
    my = 0;
    apply(8'h42);
  endtask

  initial begin
    i_rst = 1'b1;
    i_char_valid = 1'b0;
    i_char = 8'h00;
    test_reset();
    test_print_a();
    test_wrap();
    test_scroll();
    test_wrap_scroll();
    test_bs();
    test_clear();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (busy_bad != 0) begin
      n_err++;
      $display("FAIL busy_inverse: got %0d bad cycles required 0", busy_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
